// File: rtl/cla_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : cla_pkg                                                          |
// | Shared constants and stage-count derivation for the pipelined CLA adder.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package cla_pkg;

  localparam int CLA_GRP_W = 4;

  // Guards GPS < 1 so the divide stays legal while the top reports the error.
  function automatic int cla_nstg(input int width, input int gps);
    if (gps < 1) return 1;
    return width / (CLA_GRP_W * gps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_grp4.sv
// +----------------------------------------------------------------------------+
// | Module  : cla_grp4                                                         |
// | Combinational 4-bit carry-lookahead group: sum plus group generate/propagate|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla_grp4
  import cla_pkg::*;
(
  input  logic [CLA_GRP_W-1:0] a,
  input  logic [CLA_GRP_W-1:0] b,
  input  logic                 cin,
  output logic [CLA_GRP_W-1:0] sum,
  output logic                 g,
  output logic                 p
);

  logic [CLA_GRP_W-1:0] w_g;
  logic [CLA_GRP_W-1:0] w_p;
  logic                 w_c1;
  logic                 w_c2;
  logic                 w_c3;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Bit carries in flattened sum-of-products form.
  assign w_c1 = w_g[0] | (w_p[0] & cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ {w_c3, w_c2, w_c1, cin};

  assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p = &w_p;

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// +----------------------------------------------------------------------------+
// | Module  : cla_pipe_adder                                                   |
// | Pipelined carry-lookahead adder/subtractor with valid/ready backpressure.  |
// | Optional macro CLA_PIPE_OVF_EN adds the signed-overflow output out_ovf.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPS   = 2
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int SW   = CLA_GRP_W * GPS;
  localparam int NSTG = cla_nstg(WIDTH, GPS);

  if ((GPS < 1) || ((WIDTH % (CLA_GRP_W * GPS)) != 0)) begin : g_cfg_err
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*GPS and GPS >= 1");
  end

  // Per-stage record: operands travel whole, sum_lo fills in one slice per stage.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
  } stage_rec_t;

  stage_rec_t r_stg [NSTG];
  stage_rec_t w_src [NSTG];
  stage_rec_t w_nxt [NSTG];
  logic       w_adv;

  assign w_adv     = ~r_stg[NSTG-1].valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_stg[NSTG-1].valid;
  assign out_sum   = r_stg[NSTG-1].sum_lo;
  assign out_cout  = r_stg[NSTG-1].carry;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [GPS-1:0] w_g;
    logic [GPS-1:0] w_p;
    logic [GPS:0]   w_cy;
    logic [SW-1:0]  w_s;
    stage_rec_t     w_rec;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + 1; in_cin is ignored in that mode.
      assign w_src[k] = '{valid:  in_valid,
                          a_hi:   in_a,
                          b_hi:   in_sub ? ~in_b : in_b,
                          sum_lo: '0,
                          carry:  in_sub | in_cin};
    end else begin : g_link
      assign w_src[k] = r_stg[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_grp4 u_grp (
        .a   (w_src[k].a_hi[SW*k + CLA_GRP_W*j +: CLA_GRP_W]),
        .b   (w_src[k].b_hi[SW*k + CLA_GRP_W*j +: CLA_GRP_W]),
        .cin (w_cy[j]),
        .sum (w_s[CLA_GRP_W*j +: CLA_GRP_W]),
        .g   (w_g[j]),
        .p   (w_p[j])
      );
    end

    // Group carries as an OR of product terms, one term per generating group.
    always_comb begin
      logic acc;
      logic term;
      w_cy = '0;
      acc  = 1'b0;
      term = 1'b0;
      for (int j = 0; j <= GPS; j++) begin
        acc = w_src[k].carry;
        for (int i = 0; i < j; i++) acc = acc & w_p[i];
        for (int i = 0; i < j; i++) begin
          term = w_g[i];
          for (int m = i + 1; m < j; m++) term = term & w_p[m];
          acc = acc | term;
        end
        w_cy[j] = acc;
      end
    end

    always_comb begin
      w_rec                   = w_src[k];
      w_rec.sum_lo[SW*k +: SW] = w_s;
      w_rec.carry             = w_cy[GPS];
    end

    assign w_nxt[k] = w_rec;
  end

  // Bubbles only clear the valid bit, so the output sum holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) r_stg[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < NSTG; k++) begin
        if (w_nxt[k].valid) r_stg[k]       <= w_nxt[k];
        else                r_stg[k].valid <= 1'b0;
      end
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic r_ovf;
  logic w_c_msb;

  assign w_c_msb = w_src[NSTG-1].a_hi[WIDTH-1] ^ w_src[NSTG-1].b_hi[WIDTH-1]
                 ^ w_nxt[NSTG-1].sum_lo[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv && w_nxt[NSTG-1].valid) begin
      r_ovf <= w_c_msb ^ w_nxt[NSTG-1].carry;
    end
  end

  assign out_ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_cla_pipe_adder                                                |
// | Scoreboard bench for cla_pipe_adder (WIDTH=32, GPS=2).                     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cla_pipe_adder;

  localparam int WIDTH = 32;
  localparam int GPS   = 2;
  localparam int NSTG  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CLA_PIPE_OVF_EN
  logic             out_ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          t;
    bit          lat;
  } exp_t;

  exp_t sb [$];

  cla_pipe_adder #(.WIDTH(WIDTH), .GPS(GPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef CLA_PIPE_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present one beat, push its expectation when it will be accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input logic [31:0] es, input logic ec,
                      input logic eo, input bit lat);
    bit ok;
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = es; e.c = ec; e.o = eo; e.t = cyc; e.lat = lat;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles, required 1");
    end
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk(nm, sb.size(), 0);
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo);
    send(a, b, cin, sub, es, ec, eo, 1'b1);
    drain("drain_single");
  endtask

  // Monitor: compares on every output handshake and checks hold behaviour.
  initial begin
    logic [31:0] psum;
    logic        pc;
    logic        pstall;
    exp_t        e;
    psum = '0; pc = 1'b0; pstall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        psum = '0; pc = 1'b0; pstall = 1'b0;
      end else begin
        if (pstall) begin
          chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
          chk("stall_hold_sum", out_sum, psum);
          chk("stall_hold_cout", {31'b0, out_cout}, {31'b0, pc});
        end else if (!out_valid) begin
          chk("bubble_hold_sum", out_sum, psum);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got sum %h, required no result", out_sum);
          end else begin
            e = sb.pop_front();
            chk("sum", out_sum, e.s);
            chk("cout", {31'b0, out_cout}, {31'b0, e.c});
`ifdef CLA_PIPE_OVF_EN
            chk("ovf", {31'b0, out_ovf}, {31'b0, e.o});
`endif
            if (e.lat) chk("latency", cyc - e.t, NSTG);
          end
        end
        psum   = out_sum;
        pc     = out_cout;
        pstall = out_valid && !out_ready;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'hFFFF_FFFF;
    in_b      = 32'h1;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_sum", out_sum, 32'd0);
      chk("rst_out_cout", {31'b0, out_cout}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    //     A             B             cin   sub   sum           cout  ovf
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    single(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    single(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0);
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
    single(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    single(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Eight back-to-back beats; out_ready low in cycles 5-8 counted from the first beat.
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(32'hFFFF_FFFF, i, 1'b0, 1'b0, i - 1, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with beats in flight: nothing may emerge afterwards.
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h6, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_out_sum", out_sum, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
